// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Single-port framebuffer arbiter between the VGA timing generator and the
// pixel RAM. Display scanout owns every cycle whose 3-column lookahead lands
// on a visible pixel; a valid/ready pixel writer owns all remaining cycles.
// Scan reads are issued three cycles early so the pixel for column x is on
// pix_data while disp_x == x.
//
// Optional feature: define FB_STALL_CNT_EN to build the writer stall counter.
// Without it, stall_cnt is tied to zero and no counter logic exists.

module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 768,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 512,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        disp_x,
  input  logic [8:0]        disp_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start,
  output logic [15:0]       stall_cnt
);

  // Number of addressable visible pixels; anything at or above is dropped.
  localparam int unsigned PIX_TOTAL = H_ACTIVE * V_ACTIVE;

  // Lookahead distance between the read decision and the displayed pixel.
  localparam logic [10:0] LOOKAHEAD = 11'd3;

  // SYNC: waiting for the first row-0/column-0 slot, no reads issued.
  // SCAN / BLANK: locked to the raster; records whether the previous cycle
  // was a scan slot.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t state;

  // Lookahead coordinates and slot classification.
  logic [10:0]       lx_sum;
  logic              lx_wrap;
  logic [10:0]       lx;
  logic [8:0]        ly;
  logic              scan_slot;
  logic              frame_slot;
  logic              scan_issue;
  logic              xfer;
  logic              wr_in_range;

  // Scan address: the register holds the address for the next scan slot;
  // scan_cur is the address actually used this cycle (forced to 0 on the
  // first pixel of a frame so the counter self-realigns every frame).
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] scan_cur;

  // Two-deep "scan read issued" history matching the RAM read latency.
  logic              issue_d1;
  logic              issue_d2;

  // Compute the column/row the current decision is fetching for.
  always_comb begin
    // NOTE: every signal gets a default at the top of the block so no path
    // through the if below can leave it unassigned and infer a latch.
    lx_sum  = {1'b0, disp_x} + LOOKAHEAD;
    lx_wrap = (lx_sum >= 11'(H_TOTAL));
    lx      = lx_sum;
    ly      = disp_y;
    if (lx_wrap) begin
      lx = lx_sum - 11'(H_TOTAL);
      ly = (disp_y == 9'(V_TOTAL - 1)) ? 9'd0 : disp_y + 9'd1;
    end
  end

  assign scan_slot  = (lx < 11'(H_ACTIVE)) && (ly < 9'(V_ACTIVE));
  assign frame_slot = scan_slot && (lx == 11'd0) && (ly == 9'd0);

  // A read is issued on every scan slot once locked, and on the frame slot
  // that takes the block out of SYNC.
  assign scan_issue = scan_slot && ((state != SYNC) || frame_slot);

  // The writer gets every cycle the scan does not use, so the two can never
  // drive the RAM port together.
  assign wr_ready    = !scan_issue;
  assign xfer        = wr_valid && wr_ready;
  assign wr_in_range = (wr_addr < ADDR_W'(PIX_TOTAL));

  assign scan_cur = frame_slot ? '0 : scan_addr;

  // Raster lock state machine: leave SYNC only on the first frame slot,
  // then track the slot type every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (!rst_n) begin
      state <= SYNC;
    end else if ((state == SYNC) && !frame_slot) begin
      state <= SYNC;
    end else if (scan_slot) begin
      state <= SCAN;
    end else begin
      state <= BLANK;
    end
  end

  // Scan address counter: advances on every scan slot, realigned to 0 on the
  // frame slot, so no y*H_ACTIVE multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr <= '0;
    end else if (scan_slot) begin
      scan_addr <= scan_cur + ADDR_W'(1);
    end
  end

  // Registered RAM port: scan read has priority, otherwise an accepted write;
  // out-of-range writes are acknowledged, dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_err    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_err <= 1'b0;
      if (scan_issue) begin
        mem_addr <= scan_cur;
      end else if (xfer) begin
        if (wr_in_range) begin
          mem_addr  <= wr_addr;
          mem_we    <= 1'b1;
          mem_wdata <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

  // Frame start pulse lines up with mem_addr carrying address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= scan_issue && frame_slot;
    end
  end

  // Pixel output pipeline: blanking and unsynchronised cycles output black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_d1  <= 1'b0;
      issue_d2  <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      issue_d1  <= scan_issue;
      issue_d2  <= issue_d1;
      pix_valid <= issue_d2;
      pix_data  <= issue_d2 ? mem_rdata : '0;
    end
  end

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the writer waited; cleared each frame start,
  // with the clear winning over a coincident stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (frame_start) begin
      stall_q <= '0;
    end else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: drives the raster counters directly (with
// jumps to keep runs short), models a synchronous pixel RAM preloaded with
// addr[7:0], and scoreboards every displayed pixel.

module tb_vga_fb_arbiter;

  localparam int H_TOT = 768;
  localparam int V_TOT = 512;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

`ifdef FB_STALL_CNT_EN
  localparam int EXP_STALL = 640;
`else
  localparam int EXP_STALL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [9:0]  disp_x;
  logic [8:0]  disp_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic [15:0] stall_cnt;

  vga_fb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, read data one cycle after the address.
  logic [7:0] ram [0:524287];
  initial begin
    for (int i = 0; i < 524288; i++) ram[i] = 8'(i);
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at x=%0d y=%0d: got %0h, expected %0h", tag, disp_x, disp_y, obs, exp);
    end
  endtask

  // Bench-side state: pending inputs, raster position, scoreboard.
  logic        rst_p;
  logic        wv;
  logic [18:0] wa;
  logic [7:0]  wd;
  int          cx;
  int          cy;
  bit          synced;
  bit          sb_en;
  logic [7:0]  written [int];
  logic [8:0]  sb_q [$];

  // Expected {pix_valid, pix_data} while the raster is at (x, y).
  function automatic logic [8:0] exp_pix(input int x, input int y);
    int a;
    logic [7:0] d;
    if (!synced || x >= H_ACT || y >= V_ACT) return 9'h000;
    a = y * H_ACT + x;
    d = written.exists(a) ? written[a] : 8'(a);
    return {1'b1, d};
  endfunction

  // Apply one cycle of stimulus at (x, y) and queue the expected pixel.
  task automatic drive(input int x, input int y);
    @(posedge clk);
    #1;
    rst_n = rst_p;
    if (!rst_p) synced = 1'b0;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    disp_x   = 10'(x);
    disp_y   = 9'(y);
    cx = x;
    cy = y;
    if (rst_p && x == H_TOT - 3 && y == V_TOT - 1) synced = 1'b1;
    if (sb_en) sb_q.push_back(exp_pix(x, y));
  endtask

  // Sample mid-cycle and retire the oldest scoreboard entry.
  task automatic sample();
    logic [8:0] e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pix", {23'd0, pix_valid, pix_data}, {23'd0, e});
    end
  endtask

  task automatic tick();
    int nx;
    int ny;
    nx = cx + 1;
    ny = cy;
    if (nx == H_TOT) begin
      nx = 0;
      ny = (cy == V_TOT - 1) ? 0 : cy + 1;
    end
    drive(nx, ny);
    sample();
  endtask

  task automatic jump_to(input int x, input int y);
    drive(x, y);
    sample();
  endtask

  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    while (!(cx == x && cy == y) && n < 10000) begin
      tick();
      n++;
    end
    if (n >= 10000) check("run_to_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rst_p = 1'b0;
    wv = 1'b0; wa = '0; wd = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    disp_x = '0; disp_y = '0;
    cx = H_TOT - 1; cy = V_TOT - 1;
    synced = 1'b0;
    sb_en = 1'b1;

    // Reset held five cycles with free-running counters.
    repeat (5) tick();
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_pix_data",  32'(pix_data), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_wr_err",    32'(wr_err), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // SYNC: visible lookahead but no scan, writer always ready.
    rst_p = 1'b1;
    jump_to(100, 5);
    check("sync_wr_ready", 32'(wr_ready), 32'd1);
    repeat (3) tick();
    check("sync_no_scan", 32'(mem_addr), 32'd0);
    wv = 1'b1; wa = 19'd50; wd = 8'h3C;
    tick();
    check("sync_wr_ready2", 32'(wr_ready), 32'd1);
    written[50] = 8'h3C;
    wv = 1'b0;
    tick();
    check("sync_wr_we",    32'(mem_we), 32'd1);
    check("sync_wr_addr",  32'(mem_addr), 32'd50);
    check("sync_wr_wdata", 32'(mem_wdata), 32'h3C);

    // Frame start: first scan decision at (765, 511).
    jump_to(760, 511);
    run_to(765, 511);
    check("pre_fs_none", 32'(frame_start), 32'd0);
    check("pre_fs_addr", 32'(mem_addr), 32'd50);
    tick();
    check("fs_pulse", 32'(frame_start), 32'd1);
    check("fs_addr0", 32'(mem_addr), 32'd0);
    check("fs_we",    32'(mem_we), 32'd0);
    tick();
    check("fs_end",   32'(frame_start), 32'd0);
    check("fs_addr1", 32'(mem_addr), 32'd1);

    // Row 0 with a writer holding addr 100 for the whole line.
    wv = 1'b1; wa = 19'd100; wd = 8'hA5;
    tick();
    check("row_wr_ready_x0", 32'(wr_ready), 32'd0);
    run_to(636, 0);
    check("row_wr_ready_x636", 32'(wr_ready), 32'd0);
    tick();
    check("row_wr_ready_x637", 32'(wr_ready), 32'd1);
    written[100] = 8'hA5;
    tick();
    check("row_wr_we",    32'(mem_we), 32'd1);
    check("row_wr_addr",  32'(mem_addr), 32'd100);
    check("row_wr_wdata", 32'(mem_wdata), 32'hA5);
    run_to(765, 0);
    check("row_wr_ready_x765", 32'(wr_ready), 32'd0);
    run_to(767, 0);
    wv = 1'b0;
    tick();
    check("stall_line", 32'(stall_cnt), 32'(EXP_STALL));

    // Pixel content and horizontal blanking.
    run_to(5, 2);
    check("pix_5_2_data",  32'(pix_data), 32'h05);
    check("pix_5_2_valid", 32'(pix_valid), 32'd1);
    run_to(640, 2);
    check("pix_640_valid", 32'(pix_valid), 32'd0);
    check("pix_640_data",  32'(pix_data), 32'd0);

    // Out-of-range write is acknowledged and dropped; last valid address kept.
    run_to(639, 4);
    wv = 1'b1; wa = 19'd307200; wd = 8'h3C;
    tick();
    check("oor_ready", 32'(wr_ready), 32'd1);
    wv = 1'b0;
    tick();
    check("oor_err", 32'(wr_err), 32'd1);
    check("oor_we",  32'(mem_we), 32'd0);
    tick();
    check("oor_err_end", 32'(wr_err), 32'd0);
    wv = 1'b1; wa = 19'd307199; wd = 8'h7E;
    tick();
    check("last_ready", 32'(wr_ready), 32'd1);
    written[307199] = 8'h7E;
    wv = 1'b0;
    tick();
    check("last_we",   32'(mem_we), 32'd1);
    check("last_addr", 32'(mem_addr), 32'd307199);
    check("last_err",  32'(wr_err), 32'd0);

    // Next frame start clears the stall counter; frame 2 shows written pixels.
    jump_to(760, 511);
    run_to(766, 511);
    check("fs2_pulse", 32'(frame_start), 32'd1);
    check("fs2_stall_before", 32'(stall_cnt), 32'(EXP_STALL));
    tick();
    check("fs2_stall_clear", 32'(stall_cnt), 32'd0);
    run_to(767, 2);

    // Bottom of the visible area: row 479 scanned, row 480 not.
    sb_en = 1'b0;
    jump_to(760, 478);
    run_to(5, 479);
    check("row479_valid", 32'(pix_valid), 32'd1);
    run_to(100, 479);
    check("row479_ready", 32'(wr_ready), 32'd0);
    run_to(765, 479);
    check("row479_wrap_ready", 32'(wr_ready), 32'd1);
    run_to(5, 480);
    check("row480_valid", 32'(pix_valid), 32'd0);
    run_to(100, 480);
    check("row480_ready", 32'(wr_ready), 32'd1);

    // Reset mid-frame: everything clears, no scan until the next frame start.
    sb_en = 1'b1;
    rst_p = 1'b0;
    jump_to(300, 200);
    check("mid_rst_addr",  32'(mem_addr), 32'd0);
    check("mid_rst_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_stall", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    rst_p = 1'b1;
    run_to(400, 200);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    run_to(700, 200);
    check("mid_rst_no_scan", 32'(mem_addr), 32'd0);
    jump_to(760, 511);
    run_to(766, 511);
    check("resync_fs", 32'(frame_start), 32'd1);
    run_to(0, 0);
    check("resync_valid", 32'(pix_valid), 32'd1);
    run_to(20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter placed between the VGA timing generator and the pixel RAM. Display scanout reads have absolute priority. Each scan read is issued 3 cycles ahead so that the pixel for column x appears on `pix_data` while `disp_x == x`. A pixel writer (CPU/drawing engine) owns every remaining RAM cycle through a valid/ready handshake.

## Interface
- `H_ACTIVE`, 640, visible columns
- `H_TOTAL`, 768, columns per line; `disp_x` wraps at `H_TOTAL-1`
- `V_ACTIVE`, 480, visible rows
- `V_TOTAL`, 512, rows per frame; `disp_y` wraps at `V_TOTAL-1`
- `ADDR_W`, 19, framebuffer address width
- `DATA_W`, 8, pixel width

Ports:
- `clk`  in  1  pixel clock; one clock only
- `rst_n`  in  1  reset, asynchronous and active-low
- `disp_x`  in  10  horizontal counter from the timing generator
- `disp_y`  in  9  vertical counter from the timing generator
- `wr_valid`  in  1  writer request
- `wr_ready`  out  1  writer may transfer this cycle
- `wr_addr`  in  ADDR_W  pixel address, computed as y*H_ACTIVE+x
- `wr_data`  in  DATA_W  pixel value
- `wr_err`  out  1  one-cycle pulse: accepted write was out of range
- `mem_addr`  out  ADDR_W  RAM address, registered
- `mem_we`  out  1  RAM write enable, registered
- `mem_wdata`  out  DATA_W  RAM write data, registered
- `mem_rdata`  in  DATA_W  RAM read data, valid 1 cycle after `mem_addr`
- `pix_data`  out  DATA_W  pixel to the DAC, registered
- `pix_valid`  out  1  `pix_data` is a fetched framebuffer pixel
- `frame_start`  out  1  one-cycle pulse at the first scan slot of row 0
- `stall_cnt`  out  16  writer stall counter (see Configuration)

## Operation
- Lookahead column: `lx = disp_x+3`. If `lx >= H_TOTAL`, subtract `H_TOTAL` and use row `ly = (disp_y+1) mod V_TOTAL`; otherwise `ly = disp_y`.
- `scan_slot = (lx < H_ACTIVE) && (ly < V_ACTIVE)`. This is combinational and evaluated every cycle.
- `scan_addr` is an internal ADDR_W counter. It loads 0 on a scan slot with `lx==0 && ly==0`, otherwise increments on every scan slot. No multiplier.
- State machine:
  - SYNC (reset state): no scan reads; `pix_valid` = 0. Exits to SCAN on the first scan slot with `lx==0, ly==0`.
  - SCAN: current cycle is a scan slot.
  - BLANK: current cycle is not a scan slot.
  - SCAN and BLANK alternate per cycle according to `scan_slot`.
- Scan slot in SCAN: next cycle `mem_addr = scan_addr`, `mem_we = 0`.
- `wr_ready = !(scan_slot && state != SYNC)`. Writes are therefore also accepted in SYNC.
- Transfer occurs when `wr_valid && wr_ready`:
  - In range (`wr_addr < H_ACTIVE*V_ACTIVE`): next cycle `mem_addr=wr_addr`, `mem_we=1`, `mem_wdata=wr_data`.
  - Out of range: the write is acknowledged but dropped. `mem_we` stays 0 and `wr_err` pulses next cycle.
- No transfer and no scan: `mem_we = 0`, `mem_addr` holds.
- `pix_data` / `pix_valid` are registered from `mem_rdata` and a 2-deep delayed copy of "scan read issued". Non-scan cycles give `pix_data = 0` and `pix_valid = 0` (blanking is black).
- Writer and scan never collide. Same-cycle `wr_valid` with a scan slot leaves `wr_ready` low, and the writer must hold its request stable.

## Timing
- Reset (async assert, sync release): state = SYNC; `mem_addr`, `mem_we`, `mem_wdata`, `pix_data`, `pix_valid`, `wr_err`, `frame_start`, `stall_cnt` and `scan_addr` are all 0.
- Scan latency: decision at cycle t, `mem_addr` at t+1, `mem_rdata` at t+2, `pix_data` at t+3. Pixel x of row y is on `pix_data` exactly when `disp_x==x` and `disp_y==y`.
- Write latency: 1 cycle from handshake to `mem_we`.
- `frame_start` is asserted in the cycle after the row-0/column-0 scan decision, aligned with `mem_addr=0`.
- Wrap: at `disp_x = H_TOTAL-3 .. H_TOTAL-1`, the lookahead targets the next row. The row 479 → 480 transition stops scanning. Row `V_TOTAL-1` looking ahead to row 0 triggers `frame_start`.
- Reset mid-frame: the block returns to SYNC, with no scan reads and `pix_valid` = 0 until the next frame start.

## Configuration
- `FB_STALL_CNT_EN` defined:
  - `stall_cnt` increments every cycle with `wr_valid && !wr_ready`.
  - It saturates at 16'hFFFF.
  - It clears to 0 in the cycle `frame_start` pulses; a clear coincident with a stall yields 0.
- Undefined: `stall_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- Reset held 5 cycles, with counters free-running → all outputs 0; `wr_ready` = 1 in SYNC; no scan until the `disp_x=765, disp_y=511` decision; `frame_start` in the following cycle.
- RAM preloaded with `data = addr[7:0]`, one full frame → at `disp_x=5, disp_y=2`: `pix_data = 8'h05` (address 1285 & FF = 0x05), `pix_valid` = 1; at `disp_x=640`: `pix_valid` = 0 and `pix_data` = 0.
- `wr_valid` held continuously with `wr_addr=100` during the active line → `wr_ready` low during scan slots; transfer at `disp_x=637` (lx=640); `mem_we` = 1 and `mem_addr` = 100 one cycle later.
- Write to `wr_addr = 307200` → handshake completes, `mem_we` = 0, `wr_err` = 1 for one cycle.
- `rst_n` asserted at `disp_x=300, disp_y=200` → outputs 0 immediately; after release, `pix_valid` = 0 until the next frame start.
- With `FB_STALL_CNT_EN`, `wr_valid` held from `disp_y=0, disp_x=0` for one full line (768 cycles) → `stall_cnt` = 640; cleared at the next `frame_start`. Without the macro, `stall_cnt` is always 0.
